cu_sequencer: RTL and testbench
===============================

Name: cu_sequencer

Overview:
- Parametrised successor to the base processor control unit: owns its own step counter and instruction register instead of taking `state`/`ir` from outside.
- Supports NREG general registers and six ALU/move opcodes.
- Drives register-file, bus-mux, A/G and ALU controls, and signals done/illegal per instruction.
- Sits between the DIN/bus datapath and the register file.

Parameters:
- NREG, 8, number of general registers (>=2).
- RSEL_W, $clog2(NREG), register-select width (derived; do not override).
- IR_W, 3+2*RSEL_W, instruction width; layout {opcode[2:0], rx[RSEL_W-1:0], ry[RSEL_W-1:0]}.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  synchronous reset, active-high, the same as the `resetn` port in the rest of the codebase.
- run  in  1  start request; sampled only in step T0.
- din  in  IR_W  instruction word from DIN; loaded into IR in T0.
- ir_en  out  1  IR load strobe (T0 and run).
- rin  out  NREG  one-hot register write enable.
- rsel  out  RSEL_W  register index driven onto bus.
- rout_en  out  1  register-file bus driver enable.
- din_en  out  1  DIN bus driver enable.
- gout  out  1  G bus driver enable.
- ain  out  1  A register load.
- gin  out  1  G register load.
- alu_op  out  2  00 add, 01 sub, 10 and, 11 or.
- done  out  1  one-cycle pulse, last step of instruction.
- illegal  out  1  illegal opcode/register indication.
- step  out  2  current step T0..T3 (observability).

Behaviour:
- Step register: 2 bits, values T0=0, T1=1, T2=2, T3=3. IR register is IR_W bits.
- All outputs are combinational decodes of step, IR, run and resetn.
- While resetn=1, every output is forced to 0.
- On the clock edge with resetn=1: step goes to T0, IR goes to 0, the sticky error flag clears.
- T0 (fetch):
  - run=1: ir_en=1, IR<=din, step->T1.
  - run=0: stay in T0, all outputs 0.
- Opcodes are decoded from the IR in T1..T3:
  - 000 mv rx,ry: T1 rout_en=1, rsel=ry, rin[rx]=1, done=1, ->T0.
  - 001 mvi rx: T1 din_en=1, rin[rx]=1, done=1, ->T0.
  - 010 add / 011 sub / 100 and / 101 or:
    - T1: rout_en=1, rsel=rx, ain=1.
    - T2: rout_en=1, rsel=ry, gin=1, alu_op = 00/01/10/11 respectively.
    - T3: gout=1, rin[rx]=1, done=1, ->T0.
  - 110, 111: illegal.
- A register index >= NREG in rx (or in ry where ry is used) is illegal.
- Illegal instruction: T1 drives illegal=1, done=1, no rin/ain/gin, ->T0 (unless the optional feature is enabled).
- Bus exclusivity: at most one of rout_en, din_en, gout is high in any cycle. rin has at most one bit set.
- Latency from ir_en to done: mv/mvi/illegal 1 cycle; ALU ops 3 cycles. The next T0 follows done immediately, so back-to-back instructions are possible with run held high.
- run changes after T0 are ignored; an instruction always completes.
- Reset asserted mid-instruction: outputs are 0 that cycle, no partial writeback, T0 on the next cycle.
- rsel and alu_op are 0 whenever not otherwise specified.

Optional Feature:
- Macro: CU_ILLEGAL_TRAP_EN.
- Defined:
  - An illegal instruction sets a sticky error flag.
  - illegal stays 1 from T1 until reset; done still pulses once.
  - The block stays in T0 with ir_en=0 regardless of run until resetn.
- Undefined:
  - Illegal instructions act as 1-cycle NOPs.
  - illegal pulses only in T1.
  - No sticky state.

Test Plan:
- NREG=8, run=1, din=9'b000_010_000 (mv R2,R0) -> cycle0 ir_en=1; cycle1 rout_en=1 rsel=0 rin=8'h04 done=1; cycle2 step=T0.
- din=9'b001_001_000 (mvi R1) -> T1 din_en=1 rin=8'h02 done=1, rout_en=0.
- din=9'b010_010_011 (add R2,R3) -> T1 rsel=2 ain=1; T2 rsel=3 gin=1 alu_op=00; T3 gout=1 rin=8'h04 done=1. Then din=9'b011_100_101 (sub R4,R5) back-to-back -> T2 alu_op=01, T3 rin=8'h10 done=1.
- run=0 for 3 cycles -> step=0 and all outputs 0. resetn=1 during T2 of add -> that cycle gin=0 rin=0; next cycle step=T0, IR=0.
- din=9'b110_000_000:
  - Without CU_ILLEGAL_TRAP_EN -> T1 illegal=1 done=1, next fetch proceeds.
  - With the macro -> illegal held 1 and ir_en=0 with run=1 until resetn pulse.
- NREG=6 (IR_W=9), din=9'b000_110_000 (rx=6) -> illegal=1 done=1 at T1, rin=6'h00.

Source files
------------

// File: rtl/cu_sequencer_if.sv
// Control/bus bundle between cu_sequencer (master) and the DIN/bus datapath
// and register file (slave).
interface cu_sequencer_if #(
  parameter int NREG = 8
);
  localparam int RSEL_W = $clog2(NREG);
  localparam int IR_W   = 3 + 2 * RSEL_W;

  logic              run;
  logic [IR_W-1:0]   din;
  logic              ir_en;
  logic [NREG-1:0]   rin;
  logic [RSEL_W-1:0] rsel;
  logic              rout_en;
  logic              din_en;
  logic              gout;
  logic              ain;
  logic              gin;
  logic [1:0]        alu_op;
  logic              done;
  logic              illegal;
  logic [1:0]        step;

  modport master (
    input  run, din,
    output ir_en, rin, rsel, rout_en, din_en, gout, ain, gin, alu_op, done, illegal, step
  );

  modport slave (
    output run, din,
    input  ir_en, rin, rsel, rout_en, din_en, gout, ain, gin, alu_op, done, illegal, step
  );
endinterface

// File: rtl/cu_sequencer.sv
// Multi-step control unit with its own step counter and instruction register.
// Define CU_ILLEGAL_TRAP_EN to make an illegal instruction halt fetch until reset.
module cu_sequencer #(
  parameter int NREG = 8
) (
  input logic           clk,
  input logic           resetn,
  cu_sequencer_if.master bus
);
  localparam int RSEL_W = $clog2(NREG);
  localparam int IR_W   = 3 + 2 * RSEL_W;
  localparam logic [RSEL_W:0] NREG_L = (RSEL_W + 1)'(NREG);

  typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} step_t;

  step_t             step_reg;
  logic [IR_W-1:0]   ir_reg;
  logic [2:0]        opcode;
  logic [RSEL_W-1:0] rx;
  logic [RSEL_W-1:0] ry;
  logic              rx_bad;
  logic              ry_bad;
  logic              is_mv;
  logic              is_mvi;
  logic              is_alu;
  logic              ill_dec;
  logic              trapped;
  logic [2:0]        alu_idx;
  logic [NREG-1:0]   rx_onehot;

  assign opcode  = ir_reg[IR_W-1 -: 3];
  assign rx      = ir_reg[IR_W-4 -: RSEL_W];
  assign ry      = ir_reg[RSEL_W-1:0];
  assign rx_bad  = {1'b0, rx} >= NREG_L;
  assign ry_bad  = {1'b0, ry} >= NREG_L;
  assign is_mv   = (opcode == 3'd0);
  assign is_mvi  = (opcode == 3'd1);
  assign is_alu  = (opcode >= 3'd2) && (opcode <= 3'd5);
  // mvi carries no source register, so its ry field is don't-care
  assign ill_dec = (opcode[2:1] == 2'b11) || rx_bad || (ry_bad && (is_mv || is_alu));
  assign alu_idx = opcode - 3'd2;

  for (genvar gi = 0; gi < NREG; gi++) begin : g_rin
    assign rx_onehot[gi] = (rx == RSEL_W'(gi));
  end

`ifdef CU_ILLEGAL_TRAP_EN
  logic err_reg;
  assign trapped = err_reg;
`else
  assign trapped = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (resetn) begin
      step_reg <= T0;
      ir_reg   <= '0;
`ifdef CU_ILLEGAL_TRAP_EN
      err_reg  <= 1'b0;
`endif
    end else begin
      case (step_reg)
        T0: begin
          if (bus.run && !trapped) begin
            ir_reg   <= bus.din;
            step_reg <= T1;
          end
        end
        T1: begin
          step_reg <= (is_alu && !ill_dec) ? T2 : T0;
`ifdef CU_ILLEGAL_TRAP_EN
          if (ill_dec) err_reg <= 1'b1;
`endif
        end
        T2: step_reg <= T3;
        T3: step_reg <= T0;
      endcase
    end
  end

  always_comb begin
    bus.ir_en   = 1'b0;
    bus.rin     = '0;
    bus.rsel    = '0;
    bus.rout_en = 1'b0;
    bus.din_en  = 1'b0;
    bus.gout    = 1'b0;
    bus.ain     = 1'b0;
    bus.gin     = 1'b0;
    bus.alu_op  = 2'b00;
    bus.done    = 1'b0;
    bus.illegal = 1'b0;
    bus.step    = 2'b00;
    if (!resetn) begin
      bus.step = step_reg;
      case (step_reg)
        T0: bus.ir_en = bus.run && !trapped;
        T1: begin
          if (ill_dec) begin
            bus.illegal = 1'b1;
            bus.done    = 1'b1;
          end else if (is_mv) begin
            bus.rout_en = 1'b1;
            bus.rsel    = ry;
            bus.rin     = rx_onehot;
            bus.done    = 1'b1;
          end else if (is_mvi) begin
            bus.din_en  = 1'b1;
            bus.rin     = rx_onehot;
            bus.done    = 1'b1;
          end else begin
            bus.rout_en = 1'b1;
            bus.rsel    = rx;
            bus.ain     = 1'b1;
          end
        end
        T2: begin
          bus.rout_en = 1'b1;
          bus.rsel    = ry;
          bus.gin     = 1'b1;
          bus.alu_op  = alu_idx[1:0];
        end
        T3: begin
          bus.gout = 1'b1;
          bus.rin  = rx_onehot;
          bus.done = 1'b1;
        end
      endcase
      if (trapped) bus.illegal = 1'b1;
    end
  end
endmodule

// File: tb/tb_cu_sequencer.sv
// Directed-vector bench for cu_sequencer: an NREG=8 instance for the main
// instruction set and an NREG=6 instance for out-of-range register indices.
module tb_cu_sequencer;
  localparam logic [8:0] NOP  = 9'b000_000_000;
  localparam logic [8:0] MV20 = 9'b000_010_000;
  localparam logic [8:0] MVI1 = 9'b001_001_000;
  localparam logic [8:0] ADD  = 9'b010_010_011;
  localparam logic [8:0] SUB  = 9'b011_100_101;
  localparam logic [8:0] AND  = 9'b100_001_110;
  localparam logic [8:0] OR   = 9'b101_111_000;
  localparam logic [8:0] ILL  = 9'b110_000_000;
  localparam logic [8:0] MVI5 = 9'b001_101_111;
  localparam logic [8:0] MV60 = 9'b000_110_000;
  localparam logic [8:0] MV17 = 9'b000_001_111;

  logic       clk;
  logic       resetn;
  logic       run8, run6;
  logic [8:0] din8, din6;
  int         tests_run;
  int         tests_failed;

  cu_sequencer_if #(.NREG(8)) if8 ();
  cu_sequencer_if #(.NREG(6)) if6 ();

  assign if8.run = run8;
  assign if8.din = din8;
  assign if6.run = run6;
  assign if6.din = din6;

  cu_sequencer #(.NREG(8)) dut8 (.clk(clk), .resetn(resetn), .bus(if8.master));
  cu_sequencer #(.NREG(6)) dut6 (.clk(clk), .resetn(resetn), .bus(if6.master));

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Packed view: {ir_en, rin[7:0], rsel[2:0], rout_en, din_en, gout, ain, gin, alu_op, done, illegal, step}
  function automatic logic [31:0] ev(int ir_en, int rin, int rsel, int rout, int din_en, int gout,
                                     int ain, int gin, int alu, int done, int ill, int st);
    return {9'b0, 1'(ir_en), 8'(rin), 3'(rsel), 1'(rout), 1'(din_en), 1'(gout),
            1'(ain), 1'(gin), 2'(alu), 1'(done), 1'(ill), 2'(st)};
  endfunction

  function automatic logic [31:0] obs8();
    return {9'b0, if8.ir_en, if8.rin, if8.rsel, if8.rout_en, if8.din_en, if8.gout,
            if8.ain, if8.gin, if8.alu_op, if8.done, if8.illegal, if8.step};
  endfunction

  function automatic logic [31:0] obs6();
    return {9'b0, if6.ir_en, 2'b00, if6.rin, if6.rsel, if6.rout_en, if6.din_en, if6.gout,
            if6.ain, if6.gin, if6.alu_op, if6.done, if6.illegal, if6.step};
  endfunction

  // Drive one cycle's inputs, check outputs mid-cycle, advance to just past the next edge.
  task automatic cyc_chk(input string tag, input logic rst, input logic run_v,
                         input logic [8:0] din_v, input logic [31:0] exp, input logic use6);
    resetn = rst;
    if (use6) begin
      run6 = run_v;
      din6 = din_v;
    end else begin
      run8 = run_v;
      din8 = din_v;
    end
    #1;
    check_val(tag, use6 ? obs6() : obs8(), exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    clk = 1'b0;
    tests_run = 0;
    tests_failed = 0;
    resetn = 1'b1;
    run8 = 1'b0; din8 = NOP;
    run6 = 1'b0; din6 = NOP;
    @(posedge clk);
    #1;

    cyc_chk("rst_a", 1, 1, MV20, ev(0,0,0,0,0,0,0,0,0,0,0,0), 0);
    cyc_chk("rst_b", 1, 1, MV20, ev(0,0,0,0,0,0,0,0,0,0,0,0), 0);
    check_val("ir_after_rst", 32'(dut8.ir_reg), 32'd0);
    $display("[TB] reset");

    cyc_chk("mv_t0",   0, 1, MV20, ev(1,0,0,0,0,0,0,0,0,0,0,0), 0);
    cyc_chk("mv_t1",   0, 0, NOP,  ev(0,8'h04,0,1,0,0,0,0,0,1,0,1), 0);
    cyc_chk("mv_next", 0, 0, NOP,  ev(0,0,0,0,0,0,0,0,0,0,0,0), 0);
    $display("[TB] mv R2,R0");

    cyc_chk("mvi_t0", 0, 1, MVI1, ev(1,0,0,0,0,0,0,0,0,0,0,0), 0);
    cyc_chk("mvi_t1", 0, 0, NOP,  ev(0,8'h02,0,0,1,0,0,0,0,1,0,1), 0);
    $display("[TB] mvi R1");

    cyc_chk("add_t0", 0, 1, ADD, ev(1,0,0,0,0,0,0,0,0,0,0,0), 0);
    cyc_chk("add_t1", 0, 1, SUB, ev(0,0,2,1,0,0,1,0,0,0,0,1), 0);
    cyc_chk("add_t2", 0, 1, SUB, ev(0,0,3,1,0,0,0,1,0,0,0,2), 0);
    cyc_chk("add_t3", 0, 1, SUB, ev(0,8'h04,0,0,0,1,0,0,0,1,0,3), 0);
    $display("[TB] add R2,R3");
    cyc_chk("sub_t0", 0, 1, SUB, ev(1,0,0,0,0,0,0,0,0,0,0,0), 0);
    cyc_chk("sub_t1", 0, 0, NOP, ev(0,0,4,1,0,0,1,0,0,0,0,1), 0);
    cyc_chk("sub_t2", 0, 0, NOP, ev(0,0,5,1,0,0,0,1,1,0,0,2), 0);
    cyc_chk("sub_t3", 0, 0, NOP, ev(0,8'h10,0,0,0,1,0,0,0,1,0,3), 0);
    $display("[TB] sub R4,R5");

    for (int i = 0; i < 3; i++)
      cyc_chk("idle", 0, 0, MV20, ev(0,0,0,0,0,0,0,0,0,0,0,0), 0);
    $display("[TB] idle x3");

    cyc_chk("and_t0",    0, 1, AND, ev(1,0,0,0,0,0,0,0,0,0,0,0), 0);
    cyc_chk("and_t1",    0, 0, NOP, ev(0,0,1,1,0,0,1,0,0,0,0,1), 0);
    cyc_chk("and_t2rst", 1, 0, NOP, ev(0,0,0,0,0,0,0,0,0,0,0,0), 0);
    cyc_chk("and_after", 0, 0, NOP, ev(0,0,0,0,0,0,0,0,0,0,0,0), 0);
    check_val("ir_mid_rst", 32'(dut8.ir_reg), 32'd0);
    $display("[TB] and R1,R6 aborted by reset");

    cyc_chk("or_t0", 0, 1, OR,  ev(1,0,0,0,0,0,0,0,0,0,0,0), 0);
    cyc_chk("or_t1", 0, 0, NOP, ev(0,0,7,1,0,0,1,0,0,0,0,1), 0);
    cyc_chk("or_t2", 0, 0, NOP, ev(0,0,0,1,0,0,0,1,3,0,0,2), 0);
    cyc_chk("or_t3", 0, 0, NOP, ev(0,8'h80,0,0,0,1,0,0,0,1,0,3), 0);
    $display("[TB] or R7,R0");

    cyc_chk("ill_t0", 0, 1, ILL,  ev(1,0,0,0,0,0,0,0,0,0,0,0), 0);
    cyc_chk("ill_t1", 0, 1, MV20, ev(0,0,0,0,0,0,0,0,0,1,1,1), 0);
`ifdef CU_ILLEGAL_TRAP_EN
    cyc_chk("trap_a",   0, 1, MV20, ev(0,0,0,0,0,0,0,0,0,0,1,0), 0);
    cyc_chk("trap_b",   0, 1, MV20, ev(0,0,0,0,0,0,0,0,0,0,1,0), 0);
    cyc_chk("trap_rst", 1, 1, MV20, ev(0,0,0,0,0,0,0,0,0,0,0,0), 0);
    cyc_chk("trap_clr", 0, 0, NOP,  ev(0,0,0,0,0,0,0,0,0,0,0,0), 0);
`else
    cyc_chk("post_ill_t0", 0, 1, MV20, ev(1,0,0,0,0,0,0,0,0,0,0,0), 0);
    cyc_chk("post_ill_t1", 0, 0, NOP,  ev(0,8'h04,0,1,0,0,0,0,0,1,0,1), 0);
`endif
    $display("[TB] illegal opcode 110");

    cyc_chk("n6_mvi_t0", 0, 1, MVI5, ev(1,0,0,0,0,0,0,0,0,0,0,0), 1);
    cyc_chk("n6_mvi_t1", 0, 0, NOP,  ev(0,8'h20,0,0,1,0,0,0,0,1,0,1), 1);
    $display("[TB] nreg6 mvi R5 (ry=7 unused)");
    cyc_chk("n6_rx6_t0", 0, 1, MV60, ev(1,0,0,0,0,0,0,0,0,0,0,0), 1);
    cyc_chk("n6_rx6_t1", 0, 0, NOP,  ev(0,0,0,0,0,0,0,0,0,1,1,1), 1);
    $display("[TB] nreg6 mv R6,R0 illegal");
    cyc_chk("n6_rst",    1, 0, NOP,  ev(0,0,0,0,0,0,0,0,0,0,0,0), 1);
    cyc_chk("n6_ry7_t0", 0, 1, MV17, ev(1,0,0,0,0,0,0,0,0,0,0,0), 1);
    cyc_chk("n6_ry7_t1", 0, 1, MVI5, ev(0,0,0,0,0,0,0,0,0,1,1,1), 1);
`ifdef CU_ILLEGAL_TRAP_EN
    cyc_chk("n6_trap",   0, 1, MVI5, ev(0,0,0,0,0,0,0,0,0,0,1,0), 1);
`else
    cyc_chk("n6_refetch", 0, 1, MVI5, ev(1,0,0,0,0,0,0,0,0,0,0,0), 1);
`endif
    $display("[TB] nreg6 mv R1,R7 illegal");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
